// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one external combinational ALU between two requesters. A round-robin
// arbiter accepts one command at a time over a valid/ready handshake, registers
// the opcode and operands, presents them to the ALU for exactly one cycle,
// captures the result, and returns it over the owning requester's response
// handshake. Only one operation is in flight at any time.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready            command handshake for requester N (N = 0, 1)
//   reqN_op/a/b                 opcode (0 SUM, 1 SUB, 2 AND, 3 OR, 4 SHL,
//                               5 SHR, 6/7 illegal) and operands
//   rspN_valid/ready            response handshake for requester N
//   rsp_data, rsp_err           shared result bus; err flags an illegal opcode
//   alu_op/a/b, alu_r           interface to the shared combinational ALU
//   busy                        high whenever an operation is in flight
//   done_cnt                    completed response handshakes (wrapping)
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output logic [2:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_r,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             id_q, id_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;
   logic             rsp0_valid_q, rsp0_valid_d;
   logic             rsp1_valid_q, rsp1_valid_d;
   logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

   logic             grant;
   logic             req_hs;
   logic             rsp_hs;

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op <= 3'd5);
   endfunction

   // Round-robin: a contested cycle goes to whoever was not served last;
   // an uncontested one goes to the only requester asking.
   always_comb begin
      grant = req1_valid;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end
   end

   assign req0_ready = (state_q == IDLE) && !grant && req0_valid;
   assign req1_ready = (state_q == IDLE) &&  grant && req1_valid;
   assign req_hs     = req0_ready || req1_ready;

   // Only the owning requester's ready can complete a response; a ready on
   // the idle side is ignored.
   assign rsp_hs = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp1_valid_d = rsp1_valid_q;
      done_cnt_d   = done_cnt_q;

      unique case (state_q)
         // Accept: latch the winning command
         IDLE: begin
            if (req_hs) begin
               id_d         = grant;
               last_grant_d = grant;
               op_d         = grant ? req1_op : req0_op;
               a_d          = grant ? req1_a  : req0_a;
               b_d          = grant ? req1_b  : req0_b;
               state_d      = EXEC;
            end
         end
         // Execute: ALU sees the latched operands, result captured at the edge
         EXEC: begin
            if (is_legal_op(op_q)) begin
               rsp_data_d = alu_r;
               rsp_err_d  = 1'b0;
            end else begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
            end
            if (id_q) begin
               rsp1_valid_d = 1'b1;
            end else begin
               rsp0_valid_d = 1'b1;
            end
            state_d = RESP;
         end
         // Respond: hold the result until the owner takes it
         RESP: begin
            if (rsp_hs) begin
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
               done_cnt_d   = done_cnt_q + CNT_ONE;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         done_cnt_q   <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         done_cnt_q   <= done_cnt_d;
      end
   end

   // The ALU is fed straight from the operand registers, so its inputs are
   // glitch-free and simply hold their last values outside EXEC.
   assign alu_op     = op_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign busy       = (state_q != IDLE);
   assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

   localparam int W     = 8;
   // A narrow counter keeps the wrap-around reachable in a short run.
   localparam int CNT_W = 8;

   typedef struct packed {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } cmd_t;

   typedef struct {
      logic [W-1:0] data;
      logic         err;
      int           cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0]       req0_op, req1_op;
   logic [W-1:0]     req0_a, req0_b, req1_a, req1_b;
   logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [W-1:0]     rsp_data;
   logic             rsp_err;
   logic [2:0]       alu_op;
   logic [W-1:0]     alu_a, alu_b, alu_r;
   logic             busy;
   logic [CNT_W-1:0] done_cnt;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   cmd_t q0[$];
   cmd_t q1[$];
   exp_t exp_q0[$];
   exp_t exp_q1[$];
   int   grant_log[$];

   bit       hs0 = 0, hs1 = 0;
   bit       rnd_rdy = 0, rnd_gap = 0;
   bit       m_last = 1, m_busy = 0;
   int       m_done = 0;
   bit       act [2];
   logic [W-1:0] hold_data [2];
   logic         hold_err  [2];

   alu_share_arbiter #(.WIDTH(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r),
      .busy(busy), .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External ALU: legal ops are the plain arithmetic; illegal ops return
   // junk so that the zeroing of rsp_data is observable.
   function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      logic [W-1:0] r;
      case (op)
         3'd0:    r = a + b;
         3'd1:    r = a - b;
         3'd2:    r = a & b;
         3'd3:    r = a | b;
         3'd4:    r = a << 1;
         3'd5:    r = a >> 1;
         default: r = a ^ 8'h5A ^ b;
      endcase
      return r;
   endfunction

   assign alu_r = alu_fn(alu_op, alu_a, alu_b);

   task automatic chk(input string name, input int got, input int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
   endtask

   // Requester drivers: present the head of the command queue and hold it
   // until the handshake the monitor observed has happened.
   initial begin
      req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
      forever begin
         @(posedge clk); #1;
         if (hs0) begin q0.delete(0); hs0 = 0; req0_valid = 0; end
         if (!req0_valid && q0.size() != 0 && (!rnd_gap || $urandom_range(0, 3) != 0)) begin
            req0_valid = 1; req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b;
         end
      end
   end

   initial begin
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      forever begin
         @(posedge clk); #1;
         if (hs1) begin q1.delete(0); hs1 = 0; req1_valid = 0; end
         if (!req1_valid && q1.size() != 0 && (!rnd_gap || $urandom_range(0, 3) != 0)) begin
            req1_valid = 1; req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rnd_rdy) begin
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
         end
      end
   end

   task automatic check_rsp(input int n);
      logic v, r;
      exp_t e;
      v = (n == 0) ? rsp0_valid : rsp1_valid;
      r = (n == 0) ? rsp0_ready : rsp1_ready;
      if (!v) return;
      if (!act[n]) begin
         if ((n == 0 && exp_q0.size() == 0) || (n == 1 && exp_q1.size() == 0)) begin
            chk($sformatf("rsp%0d_unexpected", n), 1, 0);
         end else begin
            e = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("rsp%0d_data", n), rsp_data, e.data);
            chk($sformatf("rsp%0d_err", n), rsp_err, e.err);
            chk($sformatf("rsp%0d_latency", n), cyc - e.cyc, 2);
         end
         act[n] = 1; hold_data[n] = rsp_data; hold_err[n] = rsp_err;
      end else begin
         chk($sformatf("rsp%0d_data_stable", n), rsp_data, hold_data[n]);
         chk($sformatf("rsp%0d_err_stable", n), rsp_err, hold_err[n]);
      end
      if (r) begin
         m_done++; m_busy = 0; act[n] = 0;
      end
   endtask

   // Monitor / scoreboard: checks arbitration against the round-robin rule,
   // queues the expected result at each accepted command and checks it when
   // the response appears.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q0.delete(); exp_q1.delete();
         m_last = 1; m_busy = 0; m_done = 0; act[0] = 0; act[1] = 0;
         hs0 = 0; hs1 = 0;
      end else begin
         chk("busy", busy, m_busy);
         chk("done_cnt", done_cnt, m_done % (1 << CNT_W));
         chk("rsp_exclusive", int'(rsp0_valid && rsp1_valid), 0);
         if (req0_ready || req1_ready) begin
            cmd_t c;
            exp_t e;
            bit   g, want;
            g    = req1_ready;
            want = (req0_valid && req1_valid) ? !m_last : req1_valid;
            chk("single_ready", int'(req0_ready && req1_ready), 0);
            chk("grant", g, want);
            c = g ? cmd_t'{req1_op, req1_a, req1_b} : cmd_t'{req0_op, req0_a, req0_b};
            e.err  = (c.op > 3'd5);
            e.data = e.err ? '0 : alu_fn(c.op, c.a, c.b);
            e.cyc  = cyc;
            if (g) begin exp_q1.push_back(e); hs1 = 1; end
            else   begin exp_q0.push_back(e); hs0 = 1; end
            m_last = g; m_busy = 1;
            grant_log.push_back(int'(g));
         end
         check_rsp(0);
         check_rsp(1);
      end
   end

   task automatic wait_idle(input string name, input int limit);
      bit ok = 0;
      for (int i = 0; i < limit && !ok; i++) begin
         @(negedge clk);
         ok = q0.size() == 0 && q1.size() == 0 && exp_q0.size() == 0 &&
              exp_q1.size() == 0 && !busy && !rsp0_valid && !rsp1_valid;
      end
      chk(name, ok, 1);
   endtask

   task automatic wait_rsp(input int n, input int data, input int err, input string name);
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = (n == 0) ? rsp0_valid : rsp1_valid;
      end
      chk({name, "_seen"}, seen, 1);
      if (seen) begin
         chk({name, "_data"}, rsp_data, data);
         chk({name, "_err"}, rsp_err, err);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0; rsp0_ready = 0; rsp1_ready = 0;
      repeat (3) @(negedge clk);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done_cnt", done_cnt, 0);
      @(posedge clk); #3; rst_n = 1;

      // Single SUM with ready already high
      rsp0_ready = 1; rsp1_ready = 1;
      q0.push_back(cmd_t'{3'd0, 8'h0F, 8'h01});
      wait_rsp(0, 8'h10, 0, "sum");
      wait_idle("idle_sum", 50);
      chk("done_after_sum", done_cnt, 1);

      // Both requesters continuously valid: grants must alternate
      grant_log.delete();
      for (int i = 0; i < 4; i++) begin
         q0.push_back(cmd_t'{3'd1, 8'h05, 8'h07});
         q1.push_back(cmd_t'{3'd3, 8'hA0, 8'h05});
      end
      wait_idle("idle_alt", 200);
      chk("alt_count", grant_log.size(), 8);
      for (int i = 1; i < grant_log.size(); i++)
         chk("alt_grant", grant_log[i], 1 - grant_log[i-1]);

      // Response back-pressure on requester 1 blocks requester 0
      rsp1_ready = 0;
      q1.push_back(cmd_t'{3'd4, 8'h81, 8'hFF});
      wait_rsp(1, 8'h02, 0, "shl");
      q0.push_back(cmd_t'{3'd0, 8'h01, 8'h02});
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("blocked_req0_ready", req0_ready, 0);
         chk("held_rsp1_valid", rsp1_valid, 1);
         chk("held_rsp_data", rsp_data, 8'h02);
      end
      @(posedge clk); #1; rsp1_ready = 1;
      wait_idle("idle_block", 50);

      // Illegal opcode
      q0.push_back(cmd_t'{3'd7, 8'h33, 8'h44});
      wait_rsp(0, 0, 1, "illegal");
      wait_idle("idle_illegal", 50);

      // Reset during EXEC drops the op and returns everything to reset values
      q0.push_back(cmd_t'{3'd5, 8'h80, 8'h00});
      begin
         bit got = 0;
         for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req0_ready;
         end
         chk("rst_test_accept", got, 1);
      end
      @(posedge clk); #2;
      rst_n = 0; #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done_cnt", done_cnt, 0);
      chk("midrst_rsp0_valid", rsp0_valid, 0);
      chk("midrst_rsp_data", rsp_data, 0);
      chk("midrst_alu_a", alu_a, 0);
      @(posedge clk); #3; rst_n = 1;
      repeat (3) @(negedge clk);
      chk("postrst_rsp0_valid", rsp0_valid, 0);
      grant_log.delete();
      q0.push_back(cmd_t'{3'd2, 8'hF0, 8'h3C});
      q1.push_back(cmd_t'{3'd0, 8'hFF, 8'h02});
      wait_idle("idle_postrst", 50);
      chk("postrst_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

      // Randomized traffic, long enough to wrap the completion counter
      rnd_rdy = 1; rnd_gap = 1;
      for (int i = 0; i < 160; i++) begin
         q0.push_back(cmd_t'{3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom)});
         q1.push_back(cmd_t'{3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom)});
      end
      wait_idle("idle_random", 8000);
      rnd_rdy = 0;
      @(negedge clk);
      chk("final_done_cnt", done_cnt, m_done % (1 << CNT_W));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 8-bit combinational ALU (SUM/SUB/AND/OR/SHL/SHR) between two independent requesters.
- Uses round-robin arbitration and valid/ready handshakes on both the request and response sides.
- Registers operands, drives the ALU, captures the result and returns it to the granted requester.
- Sits between the button/switch front end (or any other command source) and the ALU datapath, replacing direct operation selection.

Parameters:
- WIDTH, 8, operand/result width in bits.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset; all state cleared on assertion, released synchronously by the system.
- req0_valid  input  1  requester 0 has a command.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_op  input  3  opcode: 0 SUM, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR, 6/7 illegal.
- req0_a  input  WIDTH  operand A.
- req0_b  input  WIDTH  operand B (ignored for SHL/SHR).
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1.
- rsp0_valid  output  1  result for requester 0 available.
- rsp0_ready  input  1  requester 0 consumes result.
- rsp1_valid  output  1  result for requester 1 available.
- rsp1_ready  input  1  requester 1 consumes result.
- rsp_data  output  WIDTH  result; meaningful only while a rspN_valid is high.
- rsp_err  output  1  1 = illegal opcode; rsp_data is 0 in that case.
- alu_op  output  3  opcode to the shared ALU.
- alu_a  output  WIDTH  operand A to the ALU.
- alu_b  output  WIDTH  operand B to the ALU.
- alu_r  input  WIDTH  combinational ALU result.
- busy  output  1  high in any state other than IDLE.
- done_cnt  output  CNT_W  count of completed response handshakes.

Behaviour:
- Reset values: state = IDLE; last_grant = 1, so requester 0 wins the first contest; op/a/b registers = 0; rsp_data = 0; rsp_err = 0; both rspN_valid = 0; done_cnt = 0. Consequently alu_op, alu_a, alu_b = 0 and busy = 0.
- The FSM has three states: IDLE, EXEC and RESP.
- IDLE, grant selection (combinational):
  - Only one valid: grant that requester.
  - Both valid: grant ~last_grant.
  - reqN_ready = (state == IDLE) && grant == N && reqN_valid. At most one ready is high per cycle.
- IDLE, on a handshake at edge E0:
  - Latch op/a/b and the granted id.
  - Set last_grant = id.
  - Go to EXEC.
- EXEC (one cycle):
  - alu_op, alu_a and alu_b are driven directly from the latched registers, stable for the whole cycle.
  - At edge E1: capture rsp_data = alu_r and rsp_err = 0 for op 0–5; rsp_data = 0 and rsp_err = 1 for op 6/7.
  - Set rsp<id>_valid = 1 and go to RESP.
- RESP:
  - Hold rsp<id>_valid, rsp_data and rsp_err stable until rsp<id>_ready.
  - On the handshake edge: clear valid, increment done_cnt (wraps 0xFFFF → 0), return to IDLE.
  - The other requester's rsp valid stays 0.
- Latency and throughput: request handshake at E0 gives rsp valid from after E1 (2 cycles). The minimum cycle per op is 3 (IDLE, EXEC, RESP with ready already high).
- Operand registers hold their last values in IDLE and RESP; the ALU outputs are don't-care outside EXEC but must not glitch to X.
- Boundary conditions:
  - A request arriving during EXEC/RESP waits; req_ready stays 0, and the requester must hold its command stable.
  - A requester may drop valid before grant with no effect.
  - Requester 0 holding valid continuously cannot starve requester 1: after any grant to 0, a pending requester 1 is served next.
  - rspN_ready asserted while rspN_valid is 0 is ignored.
  - rst_n asserted mid-EXEC/RESP: the in-flight op is dropped, no response is produced, and all outputs go to reset values immediately (asynchronously).
  - WIDTH arithmetic is modulo 2^WIDTH; carry/borrow are not reported.

Test Plan:
- Reset, then req0 op=0 a=0x0F b=0x01 with rsp0_ready held 1 -> req0_ready high 1 cycle; rsp0_valid 2 cycles later with rsp_data=0x10, rsp_err=0; done_cnt=1.
- req0 and req1 both valid continuously (req0 op=1 a=5 b=7, req1 op=3 a=0xA0 b=0x05) -> grants alternate 0,1,0,1; rsp_data alternates 0xFE, 0xA5; neither requester is starved.
- req1 op=4 a=0x81, rsp1_ready held 0 for 10 cycles -> rsp1_valid and rsp_data=0x02 stay stable; req0 is blocked (ready 0) until rsp1_ready=1.
- req0 op=7 -> rsp_err=1, rsp_data=0x00; done_cnt still increments.
- rst_n pulsed low during EXEC of req0 op=5 a=0x80 -> no rsp0_valid; busy=0 and done_cnt=0 immediately; the next request after release behaves as after reset (req0 wins a tie).
- Preload 65535 completions (or force done_cnt=0xFFFF) and complete one op -> done_cnt wraps to 0x0000.
